alu_rr_arbiter: RTL and testbench

Shares one instance of the team's 16-bit combinational ALU (bitalu_16bit) between N_REQ requesters. Each requester issues {A, B, OP} with a valid/ready handshake. Requests are granted round-robin, one per cycle. The ALU output plus flags, tagged with the requester index, goes into a single response register that the consumer drains with a valid/ready handshake. The block sits between the requester engines and the shared ALU datapath.

---
 rtl/alu_rr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one 16-bit combinational ALU between N_REQ requesters.
// Requests are granted round-robin, at most one per cycle. The ALU output is
// captured in a single response register, tagged with the requester index,
// and drained by the consumer through a valid/ready handshake.

module bitalu_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  op,
   output logic [15:0] result,
   output logic        carry,
   output logic        overflow,
   output logic        zero
);

   logic [16:0] wide;

   // ADD/SUB use a 17-bit sign-extended sum; carry is its top bit.
   always_comb begin
      wide     = '0;
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         4'b0000: begin
            wide     = {a[15], a} + {b[15], b};
            result   = wide[15:0];
            carry    = wide[16];
            overflow = (a[15] == b[15]) && (wide[15] != a[15]);
         end
         4'b0001: begin
            wide     = {a[15], a} - {b[15], b};
            result   = wide[15:0];
            carry    = wide[16];
            overflow = (a[15] != b[15]) && (wide[15] != a[15]);
         end
         4'b0010: result = a & b;
         4'b0011: result = a | b;
         4'b0100: result = a ^ b;
         4'b0101: result = ~a;
         4'b0110: result = {a[14:0], 1'b0};
         4'b0111: result = {a[15], a[15:1]};
         4'b1000: result = a + 16'd1;
         4'b1001: result = a - 16'd1;
         default: result = '0;
      endcase
   end

   assign zero = (result == 16'd0);

endmodule

module alu_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [16*N_REQ-1:0]  req_a,
   input  logic [16*N_REQ-1:0]  req_b,
   input  logic [4*N_REQ-1:0]   req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_result,
   output logic                 rsp_carry,
   output logic                 rsp_overflow,
   output logic                 rsp_zero,
   output logic                 rsp_illegal
);

   // Response register is either empty or holding one result.
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FULL = 1'b1;

   // Modulus used when wrapping candidate indices around the requester ring.
   localparam logic [ID_W+1:0] N_WIDE = (ID_W+2)'(N_REQ);

   logic [0:0]      state_reg;
   logic [ID_W-1:0] last_reg;
   logic [ID_W-1:0] id_reg;
   logic [15:0]     result_reg;
   logic            carry_reg;
   logic            overflow_reg;
   logic            zero_reg;
   logic            illegal_reg;

   logic [15:0]     a_arr   [N_REQ];
   logic [15:0]     b_arr   [N_REQ];
   logic [3:0]      op_arr  [N_REQ];
   logic [ID_W-1:0] cand_idx[N_REQ];

   logic            found;
   logic [ID_W-1:0] gnt_idx;
   logic            accept;
   logic            fire;

   logic [15:0]     sel_a;
   logic [15:0]     sel_b;
   logic [3:0]      sel_op;
   logic [15:0]     alu_result;
   logic            alu_carry;
   logic            alu_overflow;
   logic            alu_zero;
   logic            alu_illegal;

   // Unpack the flat request buses and build the rotated search order:
   // cand_idx[k] is the k-th requester examined, starting just after last_reg.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         localparam logic [ID_W+1:0] OFFSET = (ID_W+2)'(gi + 1);
         logic [ID_W+1:0] raw;

         assign a_arr[gi]    = req_a[16*gi +: 16];
         assign b_arr[gi]    = req_b[16*gi +: 16];
         assign op_arr[gi]   = req_op[4*gi +: 4];
         assign raw          = {2'b00, last_reg} + OFFSET;
         assign cand_idx[gi] = (raw >= N_WIDE) ? ID_W'(raw - N_WIDE) : ID_W'(raw);
      end
   endgenerate

   // Round-robin search: the first valid requester in rotated order wins.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_valid[cand_idx[k]]) begin
            found   = 1'b1;
            gnt_idx = cand_idx[k];
         end
      end
   end

   // A new result may load when the register is empty or being drained now.
   assign accept = (state_reg == IDLE) | rsp_ready;
   assign fire   = accept & found & rst_n;

   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_ready
         assign req_ready[gi] = fire & (gnt_idx == ID_W'(gi));
      end
   endgenerate

   assign sel_a       = a_arr[gnt_idx];
   assign sel_b       = b_arr[gnt_idx];
   assign sel_op      = op_arr[gnt_idx];
   assign alu_illegal = (sel_op >= 4'b1010);

   bitalu_16bit u_alu (
      .a        (sel_a),
      .b        (sel_b),
      .op       (sel_op),
      .result   (alu_result),
      .carry    (alu_carry),
      .overflow (alu_overflow),
      .zero     (alu_zero)
   );

   // Response register and round-robin pointer; data holds when drained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         last_reg     <= ID_W'(N_REQ - 1);
         id_reg       <= '0;
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         illegal_reg  <= 1'b0;
      end else if (fire) begin
         state_reg    <= FULL;
         last_reg     <= gnt_idx;
         id_reg       <= gnt_idx;
         result_reg   <= alu_result;
         carry_reg    <= alu_carry;
         overflow_reg <= alu_overflow;
         zero_reg     <= alu_zero;
         illegal_reg  <= alu_illegal;
      end else if (rsp_ready) begin
         state_reg    <= IDLE;
      end
   end

   assign rsp_valid    = (state_reg == FULL);
   assign rsp_id       = id_reg;
   assign rsp_result   = result_reg;
   assign rsp_carry    = carry_reg;
   assign rsp_overflow = overflow_reg;
   assign rsp_zero     = zero_reg;
   assign rsp_illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed vectors, a per-cycle behavioural
// model compare, and hand-computed literal expectations.

module tb_alu_rr_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [16*N-1:0] req_a;
   logic [16*N-1:0] req_b;
   logic [4*N-1:0]  req_op;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [15:0]   rsp_result;
   logic          rsp_carry;
   logic          rsp_overflow;
   logic          rsp_zero;
   logic          rsp_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   alu_rr_arbiter #(.N_REQ(N), .ID_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_op       (req_op),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .rsp_illegal  (rsp_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
      logic        ill;
   } alu_t;

   // Reference ALU from arithmetic meaning: signed integer sum, range overflow.
   function automatic alu_t model_alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] op);
      alu_t res;
      int   sa;
      int   sb;
      int   s;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      res = '0;
      case (op)
         4'd0: begin s = sa + sb; res.r = s[15:0]; res.c = s[16]; res.v = (s > 32767) || (s < -32768); end
         4'd1: begin s = sa - sb; res.r = s[15:0]; res.c = s[16]; res.v = (s > 32767) || (s < -32768); end
         4'd2: res.r = a & b;
         4'd3: res.r = a | b;
         4'd4: res.r = a ^ b;
         4'd5: res.r = ~a;
         4'd6: res.r = a << 1;
         4'd7: res.r = $signed(a) >>> 1;
         4'd8: res.r = a + 16'd1;
         4'd9: res.r = a - 16'd1;
         default: begin res.r = 16'd0; res.ill = 1'b1; end
      endcase
      res.z = (res.r == 16'd0);
      return res;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_op[4*i +: 4]  = op;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle model compare: expected outputs come from the model state,
   // then the model advances using the inputs that the next edge will see.
   initial begin
      logic        m_valid;
      int          m_last;
      logic [1:0]  m_id;
      alu_t        m_rsp;
      logic [N-1:0] exp_rdy;
      int          win;
      int          idx;
      m_valid = 1'b0;
      m_last  = N - 1;
      m_id    = 2'd0;
      m_rsp   = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_rdy = '0;
         win     = -1;
         if (rst_n && (!m_valid || rsp_ready)) begin
            for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (win < 0 && req_valid[idx]) win = idx;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
         end
         chk("m_req_ready",    32'(req_ready),    32'(exp_rdy));
         chk("m_rsp_valid",    32'(rsp_valid),    32'(m_valid));
         chk("m_rsp_id",       32'(rsp_id),       32'(m_id));
         chk("m_rsp_result",   32'(rsp_result),   32'(m_rsp.r));
         chk("m_rsp_carry",    32'(rsp_carry),    32'(m_rsp.c));
         chk("m_rsp_overflow", 32'(rsp_overflow), 32'(m_rsp.v));
         chk("m_rsp_zero",     32'(rsp_zero),     32'(m_rsp.z));
         chk("m_rsp_illegal",  32'(rsp_illegal),  32'(m_rsp.ill));
         if (!rst_n) begin
            m_valid = 1'b0;
            m_last  = N - 1;
            m_id    = 2'd0;
            m_rsp   = '0;
         end else if (win >= 0) begin
            m_rsp   = model_alu(req_a[16*win +: 16], req_b[16*win +: 16], req_op[4*win +: 4]);
            m_id    = 2'(win);
            m_valid = 1'b1;
            m_last  = win;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Directed stimulus with hand-computed literal expectations.
   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      set_req(0, 16'h7FFF, 16'h0001, 4'd0);
      set_req(1, 16'h1111, 16'h2222, 4'd4);
      set_req(2, 16'h0003, 16'h0005, 4'd2);
      set_req(3, 16'h00F0, 16'h000F, 4'd3);

      // Reset held with every requester valid.
      cyc();
      #2 chk("rst_ready_0", 32'(req_ready), 32'h0);
      chk("rst_valid_0", 32'(rsp_valid), 32'h0);
      cyc();
      #2 chk("rst_ready_1", 32'(req_ready), 32'h0);
      chk("rst_valid_1", 32'(rsp_valid), 32'h0);
      chk("rst_result", 32'(rsp_result), 32'h0);

      // Release: requester 0 wins first; ADD 7FFF+1 overflows.
      cyc();
      rst_n = 1'b1;
      #2 chk("first_grant", 32'(req_ready), 32'h1);
      cyc();
      req_valid = 4'b0000;
      #2 chk("add_ovf_valid", 32'(rsp_valid), 32'h1);
      chk("add_ovf_result", 32'(rsp_result), 32'h8000);
      chk("add_ovf_ovf", 32'(rsp_overflow), 32'h1);
      chk("add_ovf_carry", 32'(rsp_carry), 32'h0);
      chk("add_ovf_zero", 32'(rsp_zero), 32'h0);
      chk("add_ovf_id", 32'(rsp_id), 32'h0);

      // Requester 2: ADD FFFF+1 then SUB 0-1, back to back.
      req_valid = 4'b0100;
      set_req(2, 16'hFFFF, 16'h0001, 4'd0);
      #2 chk("req2_ready", 32'(req_ready), 32'h4);
      cyc();
      set_req(2, 16'h0000, 16'h0001, 4'd1);
      #2 chk("add_zero_result", 32'(rsp_result), 32'h0);
      chk("add_zero_zero", 32'(rsp_zero), 32'h1);
      chk("add_zero_carry", 32'(rsp_carry), 32'h0);
      chk("add_zero_ovf", 32'(rsp_overflow), 32'h0);
      chk("add_zero_id", 32'(rsp_id), 32'h2);
      cyc();
      req_valid = 4'b0000;
      #2 chk("sub_result", 32'(rsp_result), 32'hFFFF);
      chk("sub_carry", 32'(rsp_carry), 32'h1);
      chk("sub_ovf", 32'(rsp_overflow), 32'h0);
      cyc();
      #2 chk("drain_valid", 32'(rsp_valid), 32'h0);
      chk("drain_hold", 32'(rsp_result), 32'hFFFF);

      // Move pointer to 3, then all four valid: ids 0,1,2,3,0,1.
      req_valid = 4'b1000;
      set_req(3, 16'hF0F0, 16'h0FF0, 4'd2);
      cyc();
      req_valid = 4'b1111;
      set_req(0, 16'h0001, 16'h0002, 4'd0);
      set_req(1, 16'h1234, 16'h4321, 4'd3);
      set_req(2, 16'h8001, 16'h0000, 4'd6);
      set_req(3, 16'h8002, 16'h0000, 4'd7);
      for (int k = 0; k < 6; k++) begin
         #2 chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
         cyc();
         #2 chk("rr_id", 32'(rsp_id), 32'(k % 4));
      end

      // Backpressure: requester 1 SUB 8000-1 held for 5 cycles.
      req_valid = 4'b0010;
      set_req(1, 16'h8000, 16'h0001, 4'd1);
      #2 chk("bp_grant", 32'(req_ready), 32'h2);
      cyc();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      set_req(0, 16'h1234, 16'h1111, 4'd0);
      for (int k = 0; k < 5; k++) begin
         #2 chk("bp_valid", 32'(rsp_valid), 32'h1);
         chk("bp_result", 32'(rsp_result), 32'h7FFF);
         chk("bp_ovf", 32'(rsp_overflow), 32'h1);
         chk("bp_ready", 32'(req_ready), 32'h0);
         cyc();
      end
      rsp_ready = 1'b1;
      #2 chk("bp_release_ready", 32'(req_ready), 32'h1);
      cyc();
      #2 chk("no_bubble_valid", 32'(rsp_valid), 32'h1);
      chk("no_bubble_result", 32'(rsp_result), 32'h2345);
      chk("no_bubble_id", 32'(rsp_id), 32'h0);

      // Illegal opcode on requester 3, then reset while response is held.
      req_valid = 4'b1000;
      set_req(3, 16'h5555, 16'hAAAA, 4'b1100);
      #2 chk("ill_grant", 32'(req_ready), 32'h8);
      cyc();
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      #2 chk("ill_flag", 32'(rsp_illegal), 32'h1);
      chk("ill_result", 32'(rsp_result), 32'h0);
      chk("ill_zero", 32'(rsp_zero), 32'h1);
      chk("ill_id", 32'(rsp_id), 32'h3);
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      #2 chk("midrst_ready", 32'(req_ready), 32'h0);
      cyc();
      #2 chk("midrst_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_illegal", 32'(rsp_illegal), 32'h0);
      chk("midrst_id", 32'(rsp_id), 32'h0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #2 chk("post_rst_grant", 32'(req_ready), 32'h1);
      cyc();
      req_valid = 4'b0000;
      cyc();
      cyc();
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
